udp_line_scheduler: RTL and testbench
=====================================

UDP_LINE_SCHEDULER -- requirements
Module: udp_line_scheduler

Interface
REQ-001 Param H_ACT, default 1280, bytes per line sent per UDP packet.
REQ-002 Param V_ACT, default 720, rows per frame per camera.
REQ-003 Param GAP_CYCLES, default 64, idle clk cycles between packets (min 1).
REQ-004 Param TIMEOUT, default 1_000_000, max clk cycles in any wait state.
REQ-005 clk  in  1  rgmii_clk domain, the only clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  level; streaming is allowed while high.
REQ-008 connected  in  1  level; link/ARP resolved flag from the UDP stack.
REQ-009 frame_start  in  1  single-cycle pulse that requests one full dual-camera frame.
REQ-010 lb_ready  in  1  line buffer holds the requested line and is valid to read.
REQ-011 lb_error  in  1  line buffer overflow/underflow flag.
REQ-012 tx_read_en  in  1  UDP stack consumed one payload byte this cycle.
REQ-013 lb_trig  out  1  single-cycle pulse requesting the line (cur_cam, cur_row).
REQ-014 udp_trig  out  1  single-cycle pulse that starts one UDP packet.
REQ-015 cur_cam  out  1  camera index of the current line (0 = cam1, 1 = cam2).
REQ-016 cur_row  out  10  row index of the current line.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 frame_done  out  1  single-cycle pulse after the last line of a frame is sent.
REQ-019 timeout_err  out  1  sticky flag; cleared by rst or the next accepted frame_start.

Function
REQ-020 FSM states: IDLE, ARM, WAIT_LB, SEND, STREAM, GAP.
REQ-021 IDLE: on frame_start && enable && connected, go to ARM and clear cur_cam, cur_row and timeout_err.
REQ-022 IDLE: frame_start is ignored when enable or connected is low; no flag is raised.
REQ-023 ARM: assert lb_trig for exactly one cycle, then go to WAIT_LB.
REQ-024 WAIT_LB: on lb_ready, go to SEND. lb_ready sampled in ARM is not counted.
REQ-025 SEND: assert udp_trig for exactly one cycle, clear the byte counter, then go to STREAM.
REQ-026 STREAM: increment the byte counter on each tx_read_en; when the count reaches H_ACT, go to GAP.
REQ-027 STREAM: tx_read_en beyond H_ACT is ignored; the counter saturates.
REQ-028 GAP: wait GAP_CYCLES cycles, then advance the line:
- cur_cam toggles.
- When cur_cam was 1, cur_row increments.
REQ-029 GAP end with cur_cam=1 and cur_row=V_ACT-1: pulse frame_done, go to IDLE, and reset cur_cam/cur_row to 0.
REQ-030 GAP end otherwise: go to ARM. Latency from lb_ready to udp_trig is 1 cycle.
REQ-031 Timeout counter: reset on every state entry; counts in WAIT_LB and STREAM. Reaching TIMEOUT sets timeout_err and forces IDLE.
REQ-032 lb_error high in any non-IDLE state sets timeout_err and forces IDLE on the next cycle.
REQ-033 connected falling in any state forces IDLE on the next cycle without setting timeout_err.
REQ-034 enable falling lets the current packet finish through GAP, then goes to IDLE with no frame_done.
REQ-035 If abort (REQ-031/032/033) and frame_done occur in the same cycle, abort wins and no frame_done is issued.
REQ-036 frame_start while busy is ignored.
REQ-037 All outputs are registered; lb_trig, udp_trig and frame_done are never high simultaneously.

Reset
REQ-038 On rst: state=IDLE, and lb_trig, udp_trig, frame_done, timeout_err, busy, cur_cam, cur_row and all counters are 0.
REQ-039 Reset mid-packet abandons the packet immediately; no trailing pulses are produced after rst deasserts.

Structure
REQ-040 The FSM state enum and the default H_ACT/V_ACT constants belong in the shared package aimbot_pkg.
REQ-041 One sub-module, sched_timeout_cnt (a loadable timeout counter), is natural; all other logic is inline.

Verification
REQ-042 H_ACT=4, V_ACT=2, GAP=2: frame_start, lb_ready 2 cycles after each lb_trig, 4 tx_read_en per packet.
- Required: 4 packets in (cam,row) order (0,0)(1,0)(0,1)(1,1), then one frame_done.
REQ-043 lb_ready never asserted, TIMEOUT=16: timeout_err=1 exactly 16 cycles after WAIT_LB entry, busy=0 next cycle.
REQ-044 connected dropped during STREAM after 2 bytes: IDLE next cycle, timeout_err=0, no frame_done.
REQ-045 rst pulsed mid-STREAM: all outputs 0 on assertion; no lb_trig or udp_trig until the next frame_start.
REQ-046 frame_start repeated while busy, and 6 tx_read_en in a 4-byte packet: second request ignored, exactly 4 packets sent.
REQ-047 lb_error asserted in GAP: timeout_err=1, IDLE next cycle, cur_row/cur_cam=0.

Source files
------------

// File: rtl/aimbot_pkg.sv
// Shared types and default frame geometry for the camera-to-UDP streaming path.
package aimbot_pkg;

  localparam int unsigned H_ACT_DEF = 32'd1280;
  localparam int unsigned V_ACT_DEF = 32'd720;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_WAIT_LB = 3'd2,
    S_SEND    = 3'd3,
    S_STREAM  = 3'd4,
    S_GAP     = 3'd5
  } sched_state_e;

  // States in which the scheduler waits on an external party and must be bounded.
  function automatic logic is_timed_state(input sched_state_e s);
    return (s == S_WAIT_LB) || (s == S_STREAM);
  endfunction

endpackage

// File: rtl/sched_timeout_cnt.sv
// Loadable watchdog counter: hit rises on the LIMIT-th counted cycle since the last load.
module sched_timeout_cnt #(
  parameter int unsigned LIMIT = 32'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic hit
);

  localparam int unsigned W = (LIMIT > 32'd1) ? $clog2(LIMIT) : 32'd1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 32'd1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign hit = en && (cnt_q == LAST);

  // Next count: load to zero, otherwise count up and hold at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/udp_line_scheduler.sv
// Walks a dual-camera frame line by line (cam0/cam1 per row), fetching each line from the
// line buffer and pacing it out as one UDP packet; faults and link loss drop back to IDLE.
module udp_line_scheduler
  import aimbot_pkg::*;
#(
  parameter int unsigned H_ACT      = H_ACT_DEF,
  parameter int unsigned V_ACT      = V_ACT_DEF,
  parameter int unsigned GAP_CYCLES = 32'd64,
  parameter int unsigned TIMEOUT    = 32'd1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       connected,
  input  logic       frame_start,
  input  logic       lb_ready,
  input  logic       lb_error,
  input  logic       tx_read_en,
  output logic       lb_trig,
  output logic       udp_trig,
  output logic       cur_cam,
  output logic [9:0] cur_row,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);

  localparam int unsigned BW = $clog2(H_ACT + 32'd1);
  localparam int unsigned GW = (GAP_CYCLES > 32'd1) ? $clog2(GAP_CYCLES) : 32'd1;
  localparam logic [BW-1:0] BYTE_FULL = BW'(H_ACT);
  localparam logic [BW-1:0] BYTE_LAST = BW'(H_ACT - 32'd1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 32'd1);
  localparam logic [9:0]    ROW_LAST  = 10'(V_ACT - 32'd1);

  sched_state_e  state_q, state_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          stop_q, stop_d;
  logic          cur_cam_q, cur_cam_d;
  logic [9:0]    cur_row_q, cur_row_d;
  logic          timeout_err_q, timeout_err_d;
  logic          frame_done_q, frame_done_d;
  logic          lb_trig_q, lb_trig_d;
  logic          udp_trig_q, udp_trig_d;
  logic          busy_q, busy_d;
  logic          to_hit;
  logic          to_load;

  // Watchdog restarts on every state change so each wait gets the full budget.
  assign to_load = (state_d != state_q);

  sched_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .load (to_load),
    .en   (is_timed_state(state_q)),
    .hit  (to_hit)
  );

  // Next-state, line bookkeeping and registered-output decode.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    stop_d        = stop_q;
    cur_cam_d     = cur_cam_q;
    cur_row_d     = cur_row_q;
    timeout_err_d = timeout_err_q;
    frame_done_d  = 1'b0;

    if (state_q == S_IDLE) begin
      stop_d = 1'b0;
      if (frame_start && enable && connected) begin
        state_d       = S_ARM;
        cur_cam_d     = 1'b0;
        cur_row_d     = 10'd0;
        timeout_err_d = 1'b0;
      end else begin
        state_d = S_IDLE;
      end
    end else if (lb_error || to_hit || !connected) begin
      // Aborts are checked first so they suppress a frame_done due this same cycle.
      state_d       = S_IDLE;
      cur_cam_d     = 1'b0;
      cur_row_d     = 10'd0;
      timeout_err_d = timeout_err_q | lb_error | to_hit;
    end else begin
      stop_d = stop_q | ~enable;
      case (state_q)
        S_ARM: begin
          state_d = S_WAIT_LB;
        end
        S_WAIT_LB: begin
          if (lb_ready) begin
            state_d = S_SEND;
          end else begin
            state_d = S_WAIT_LB;
          end
        end
        S_SEND: begin
          byte_cnt_d = '0;
          state_d    = S_STREAM;
        end
        S_STREAM: begin
          if (tx_read_en && (byte_cnt_q == BYTE_LAST)) begin
            byte_cnt_d = BYTE_FULL;
            gap_cnt_d  = '0;
            state_d    = S_GAP;
          end else if (tx_read_en && (byte_cnt_q != BYTE_FULL)) begin
            byte_cnt_d = byte_cnt_q + BW'(1);
          end else begin
            byte_cnt_d = byte_cnt_q;
          end
        end
        S_GAP: begin
          if (gap_cnt_q != GAP_LAST) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end else if (stop_q || !enable) begin
            state_d   = S_IDLE;
            cur_cam_d = 1'b0;
            cur_row_d = 10'd0;
          end else if (cur_cam_q && (cur_row_q == ROW_LAST)) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
            cur_cam_d    = 1'b0;
            cur_row_d    = 10'd0;
          end else begin
            state_d   = S_ARM;
            cur_cam_d = ~cur_cam_q;
            cur_row_d = cur_cam_q ? (cur_row_q + 10'd1) : cur_row_q;
          end
        end
        default: begin
          state_d   = S_IDLE;
          cur_cam_d = 1'b0;
          cur_row_d = 10'd0;
        end
      endcase
    end

    lb_trig_d  = (state_d == S_ARM);
    udp_trig_d = (state_d == S_SEND);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      stop_q        <= 1'b0;
      cur_cam_q     <= 1'b0;
      cur_row_q     <= 10'd0;
      timeout_err_q <= 1'b0;
      frame_done_q  <= 1'b0;
      lb_trig_q     <= 1'b0;
      udp_trig_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      stop_q        <= stop_d;
      cur_cam_q     <= cur_cam_d;
      cur_row_q     <= cur_row_d;
      timeout_err_q <= timeout_err_d;
      frame_done_q  <= frame_done_d;
      lb_trig_q     <= lb_trig_d;
      udp_trig_q    <= udp_trig_d;
      busy_q        <= busy_d;
    end
  end

  assign lb_trig     = lb_trig_q;
  assign udp_trig    = udp_trig_q;
  assign cur_cam     = cur_cam_q;
  assign cur_row     = cur_row_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_udp_line_scheduler.sv
// Directed bench for udp_line_scheduler with a tiny 4-byte x 2-row frame and a 16-cycle watchdog.
module tb_udp_line_scheduler;

  localparam int unsigned H = 32'd4;
  localparam int unsigned V = 32'd2;
  localparam int unsigned G = 32'd2;
  localparam int unsigned T = 32'd16;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       connected;
  logic       frame_start;
  logic       lb_ready;
  logic       lb_error;
  logic       tx_read_en;
  logic       lb_trig;
  logic       udp_trig;
  logic       cur_cam;
  logic [9:0] cur_row;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int n_lb, n_udp, n_done, n_overlap, lat_bad;
  int lb_cd, tx_left, tx_per_pkt;
  bit auto_lb;
  logic [10:0] pkts[$];
  int n_wait;

  always #5 clk = ~clk;

  udp_line_scheduler #(
    .H_ACT      (H),
    .V_ACT      (V),
    .GAP_CYCLES (G),
    .TIMEOUT    (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .connected   (connected),
    .frame_start (frame_start),
    .lb_ready    (lb_ready),
    .lb_error    (lb_error),
    .tx_read_en  (tx_read_en),
    .lb_trig     (lb_trig),
    .udp_trig    (udp_trig),
    .cur_cam     (cur_cam),
    .cur_row     (cur_row),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: observe outputs just after the edge, then play the line buffer / UDP stack.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (lb_trig) n_lb++;
    if (udp_trig) begin
      n_udp++;
      pkts.push_back({cur_cam, cur_row});
      if (!lb_ready) lat_bad++;
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (32'(lb_trig) + 32'(udp_trig) + 32'(frame_done) > 32'd1) n_overlap++;
    if (lb_cd != 0) begin
      lb_cd--;
      lb_ready = (lb_cd == 0);
    end else begin
      lb_ready = 1'b0;
    end
    if (lb_trig && auto_lb) lb_cd = 2;
    if (tx_left != 0) begin
      tx_read_en = 1'b1;
      tx_left--;
    end else begin
      tx_read_en = 1'b0;
    end
    if (udp_trig) tx_left = tx_per_pkt;
  endtask

  task automatic clear_stats();
    n_lb = 0; n_udp = 0; n_done = 0; lat_bad = 0;
    lb_cd = 0; tx_left = 0; lb_ready = 1'b0; tx_read_en = 1'b0;
    pkts.delete();
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_udp(input int target);
    int k = 0;
    while (n_udp < target && k < 200) begin
      tick();
      k++;
    end
    if (n_udp < target) chk("wait_udp", 32'(n_udp), 32'(target));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    if (busy) chk("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_lb_trig"}, 32'(lb_trig), 32'd0);
    chk({pfx, "_udp_trig"}, 32'(udp_trig), 32'd0);
    chk({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({pfx, "_cur_cam"}, 32'(cur_cam), 32'd0);
    chk({pfx, "_cur_row"}, 32'(cur_row), 32'd0);
  endtask

  // Full frame must be (0,0)(1,0)(0,1)(1,1), i.e. cam = i%2, row = i/2.
  task automatic check_pkts(input string pfx);
    logic [10:0] got;
    logic [10:0] exp;
    chk({pfx, "_pkt_cnt"}, 32'(pkts.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = (i < pkts.size()) ? pkts[i] : 11'h7ff;
      exp = {1'(i % 2), 10'(i / 2)};
      chk($sformatf("%s_pkt%0d", pfx, i), 32'(got), 32'(exp));
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; connected = 1'b0; frame_start = 1'b0;
    lb_ready = 1'b0; lb_error = 1'b0; tx_read_en = 1'b0;
    n_overlap = 0; auto_lb = 1'b1; tx_per_pkt = 4;
    clear_stats();
    tick(); tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // frame_start ignored while disabled or disconnected
    connected = 1'b1; enable = 1'b0;
    pulse_start(); tick(); tick();
    chk("noen_busy", 32'(busy), 32'd0);
    chk("noen_lb", 32'(n_lb), 32'd0);
    enable = 1'b1; connected = 1'b0;
    pulse_start(); tick(); tick();
    chk("nocon_busy", 32'(busy), 32'd0);
    chk("nocon_lb", 32'(n_lb), 32'd0);
    chk("nocon_err", 32'(timeout_err), 32'd0);
    connected = 1'b1;

    // full frame: 10 cycles per line, frame_done 40 cycles after the ARM edge
    clear_stats(); auto_lb = 1'b1; tx_per_pkt = 4;
    pulse_start();
    chk("frame_arm_lb", 32'(lb_trig), 32'd1);
    chk("frame_busy", 32'(busy), 32'd1);
    wait_idle(n_wait);
    chk("frame_udp", 32'(n_udp), 32'd4);
    chk("frame_lb", 32'(n_lb), 32'd4);
    chk("frame_done", 32'(n_done), 32'd1);
    chk("frame_len", 32'(done_cyc - start_cyc), 32'd40);
    chk("frame_lat", 32'(lat_bad), 32'd0);
    chk("frame_err", 32'(timeout_err), 32'd0);
    chk("frame_cam", 32'(cur_cam), 32'd0);
    chk("frame_row", 32'(cur_row), 32'd0);
    check_pkts("frame");

    // watchdog: no lb_ready, error exactly 16 cycles after WAIT_LB entry
    clear_stats(); auto_lb = 1'b0;
    pulse_start();
    repeat (16) tick();
    chk("to_pre_err", 32'(timeout_err), 32'd0);
    chk("to_pre_busy", 32'(busy), 32'd1);
    tick();
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    tick();
    chk("to_busy_next", 32'(busy), 32'd0);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    chk("to_udp", 32'(n_udp), 32'd0);

    // link loss after 2 bytes in STREAM
    clear_stats(); auto_lb = 1'b1; tx_per_pkt = 2;
    pulse_start();
    chk("con_err_clr", 32'(timeout_err), 32'd0);
    wait_udp(1);
    repeat (3) tick();
    chk("con_pre_busy", 32'(busy), 32'd1);
    connected = 1'b0;
    tick();
    chk("con_busy", 32'(busy), 32'd0);
    chk("con_err", 32'(timeout_err), 32'd0);
    repeat (5) tick();
    chk("con_done", 32'(n_done), 32'd0);
    chk("con_udp", 32'(n_udp), 32'd1);
    connected = 1'b1;

    // asynchronous reset mid-STREAM
    clear_stats(); tx_per_pkt = 4;
    pulse_start();
    wait_udp(1);
    tick(); tick();
    rst = 1'b1;
    #1;
    check_zero("midrst");
    tick();
    lb_cd = 0; tx_left = 0;
    rst = 1'b0;
    repeat (20) tick();
    chk("midrst_lb", 32'(n_lb), 32'd1);
    chk("midrst_udp", 32'(n_udp), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);

    // repeated frame_start while busy, 6 bytes offered per 4-byte packet
    clear_stats(); tx_per_pkt = 6;
    pulse_start();
    wait_udp(1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    wait_udp(3);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    wait_idle(n_wait);
    chk("rep_udp", 32'(n_udp), 32'd4);
    chk("rep_done", 32'(n_done), 32'd1);
    chk("rep_len", 32'(done_cyc - start_cyc), 32'd40);
    check_pkts("rep");
    repeat (10) tick();
    chk("rep_lb_after", 32'(n_lb), 32'd4);

    // enable drop: current packet completes through GAP, no frame_done
    clear_stats(); tx_per_pkt = 4;
    pulse_start();
    wait_udp(1);
    enable = 1'b0;
    wait_idle(n_wait);
    chk("en_drain_cycles", 32'(n_wait), 32'd7);
    chk("en_udp", 32'(n_udp), 32'd1);
    chk("en_done", 32'(n_done), 32'd0);
    enable = 1'b1;

    // lb_error in GAP of the third line (cam0,row1)
    clear_stats(); tx_per_pkt = 4;
    pulse_start();
    wait_udp(3);
    repeat (5) tick();
    chk("lberr_pre_row", 32'(cur_row), 32'd1);
    chk("lberr_pre_busy", 32'(busy), 32'd1);
    lb_error = 1'b1;
    tick();
    lb_error = 1'b0;
    chk("lberr_busy", 32'(busy), 32'd0);
    chk("lberr_err", 32'(timeout_err), 32'd1);
    chk("lberr_cam", 32'(cur_cam), 32'd0);
    chk("lberr_row", 32'(cur_row), 32'd0);
    repeat (5) tick();
    chk("lberr_done", 32'(n_done), 32'd0);
    chk("lberr_lb", 32'(n_lb), 32'd3);

    chk("pulse_exclusive", 32'(n_overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
